// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM between instruction fetch (reads only) and data access (reads and writes).
// Port A is the data side's write port. Port B reads are arbitrated, with a burst limit and a lock for read-modify-write.
module ram_port_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [DW-1:0] fetch_rdata,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    input  logic          data_lock,
    output logic          data_gnt,
    output logic          data_rvalid,
    output logic [DW-1:0] data_rdata,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_dob,
    output logic          dbg_pri_state,
    output logic          dbg_lock
);
    localparam logic PRI_FETCH = 1'b0;
    localparam logic PRI_DATA  = 1'b1;
    localparam int   CW        = $clog2(MAX_BURST + 1);

    logic          r_state;
    logic [CW-1:0] r_burst;
    logic          r_lock;
    logic          r_fetch_rvalid;
    logic          r_data_rvalid;
    logic          r_fwd;
    logic [DW-1:0] r_fwd_data;

    logic          w_data_wr;
    logic          w_data_rd;
    logic          w_fetch_rd;
    logic          w_contend;
    logic          w_fetch_gnt;
    logic          w_data_rd_gnt;
    logic [AW-1:0] w_rd_addr;
    logic          w_fwd_hit;

    // Handshake: a transfer happens in any cycle where req && gnt. The requester holds addr/we/wdata while req=1 and gnt=0.
    // Grants are combinational. Read data comes back exactly one cycle after the grant.
    // Every term is qualified by rst, so all outputs stay at 0 while the block is held in reset.
    always_comb begin
        w_data_wr     = rst && data_req && data_we;
        w_data_rd     = rst && data_req && !data_we;
        w_fetch_rd    = rst && fetch_req && !r_lock;
        w_contend     = w_fetch_rd && w_data_rd;
        w_fetch_gnt   = w_fetch_rd && (!w_data_rd || (r_state == PRI_FETCH));
        w_data_rd_gnt = w_data_rd && !w_fetch_gnt;
        w_rd_addr     = w_fetch_gnt ? fetch_addr : data_addr;
        w_fwd_hit     = (w_fetch_gnt || w_data_rd_gnt) && w_data_wr && (w_rd_addr == data_addr);
    end

    assign fetch_gnt = w_fetch_gnt;
    assign data_gnt  = w_data_wr || w_data_rd_gnt;
    assign ram_ena   = w_data_wr;
    assign ram_wea   = w_data_wr;
    assign ram_addra = w_data_wr ? data_addr : '0;
    assign ram_dia   = w_data_wr ? data_wdata : '0;
    assign ram_enb   = w_fetch_gnt || w_data_rd_gnt;
    assign ram_addrb = ram_enb ? w_rd_addr : '0;

    // The RAM returns the old word on a same-address collision, so the new write data is replayed instead.
    assign fetch_rvalid = r_fetch_rvalid;
    assign data_rvalid  = r_data_rvalid;
    assign fetch_rdata  = r_fetch_rvalid ? (r_fwd ? r_fwd_data : ram_dob) : '0;
    assign data_rdata   = r_data_rvalid ? (r_fwd ? r_fwd_data : ram_dob) : '0;

    assign dbg_pri_state = r_state;
    assign dbg_lock      = r_lock;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_fetch_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
            r_fwd          <= 1'b0;
            r_fwd_data     <= '0;
        end else begin
            r_fetch_rvalid <= w_fetch_gnt;
            r_data_rvalid  <= w_data_rd_gnt;
            r_fwd          <= w_fwd_hit;
            r_fwd_data     <= data_wdata;
        end
    end

    // Priority only moves when the burst limit is reached under contention. The lock freezes it.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_state <= PRI_FETCH;
            r_burst <= '0;
        end else if (!r_lock) begin
            if (w_contend) begin
                if (r_burst == CW'(MAX_BURST - 1)) begin
                    r_state <= (r_state == PRI_FETCH) ? PRI_DATA : PRI_FETCH;
                    r_burst <= '0;
                end else begin
                    r_burst <= r_burst + 1'b1;
                end
            end else begin
                r_burst <= '0;
            end
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_lock <= 1'b0;
        end else if (w_data_wr) begin
            r_lock <= 1'b0;
        end else if (w_data_rd_gnt) begin
            r_lock <= data_lock;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, directed scenarios, then randomized traffic.
// A request/response reference model checks every cycle.
module tb_ram_port_arbiter;
    localparam int AW        = 10;
    localparam int DW        = 16;
    localparam int MAX_BURST = 4;

    logic          clka = 1'b0;
    logic          rst  = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_gnt, fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          data_req = 1'b0, data_we = 1'b0, data_lock = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_gnt, data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          ram_ena, ram_wea, ram_enb;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dia, ram_dob;
    logic          dbg_pri_state, dbg_lock;

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clka(clka), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_lock(data_lock), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
        .dbg_pri_state(dbg_pri_state), .dbg_lock(dbg_lock)
    );

    // ---------------- clock ----------------
    always #5 clka = ~clka;

    // ---------------- behavioural RAM (read-first on collision) ----------------
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_word(input int i);
        return 16'h0401 + 16'(i * 16'h0103);
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = init_word(i);
            exp_mem[i] = init_word(i);
        end
        ram_dob = '0;
    end

    always @(posedge clka) begin
        if (ram_enb) ram_dob <= ram_mem[ram_addrb];
        if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dia;
    end

    // ---------------- scoreboard / reference model ----------------
    int n_tests = 0;
    int n_fail  = 0;

    bit            m_pri;          // 0 = fetch has priority, 1 = data
    int            m_cnt;
    bit            m_lock;
    logic [DW-1:0] exp_fq[$];      // expected fetch read data, one entry per grant
    logic [DW-1:0] exp_dq[$];
    bit            m_fg, m_dg;
    logic          obs_fg, obs_dg, obs_drv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pri  = 1'b0;
        m_cnt  = 0;
        m_lock = 1'b0;
        exp_fq.delete();
        exp_dq.delete();
    endtask

    // One clock cycle with rst=0. Entered at posedge+1 and left at the next posedge+1.
    task automatic reset_cycle();
        #3;
        check("rst_fetch_gnt", fetch_gnt, 0);
        check("rst_data_gnt", data_gnt, 0);
        check("rst_fetch_rvalid", fetch_rvalid, 0);
        check("rst_data_rvalid", data_rvalid, 0);
        check("rst_rdata", {fetch_rdata, data_rdata}, 0);
        check("rst_ram_ctl", {ram_ena, ram_wea, ram_enb}, 0);
        check("rst_ram_bus", {ram_addra, ram_dia, ram_addrb}, 0);
        check("rst_state", {dbg_pri_state, dbg_lock}, 0);
        model_reset();
        @(posedge clka);
        #1;
    endtask

    // One clock cycle with rst=1. The model decides the grants, checks the DUT, then advances.
    task automatic step();
        bit d_wr, d_rd, fg, drg;
        logic [DW-1:0] v;
        #3;
        d_wr = data_req && data_we;
        d_rd = data_req && !data_we;
        if (m_lock) begin
            fg  = 1'b0;
            drg = d_rd;
        end else if (fetch_req && d_rd) begin
            fg  = (m_pri == 1'b0);
            drg = !fg;
        end else begin
            fg  = fetch_req;
            drg = d_rd;
        end
        check("fetch_gnt", fetch_gnt, fg);
        check("data_gnt", data_gnt, d_wr || drg);
        check("fetch_rvalid", fetch_rvalid, exp_fq.size() != 0);
        if (exp_fq.size() != 0) begin
            v = exp_fq.pop_front();
            check("fetch_rdata", fetch_rdata, v);
        end
        check("data_rvalid", data_rvalid, exp_dq.size() != 0);
        if (exp_dq.size() != 0) begin
            v = exp_dq.pop_front();
            check("data_rdata", data_rdata, v);
        end
        check("ram_ena_wea", {ram_ena, ram_wea}, {d_wr, d_wr});
        if (d_wr) check("ram_write", {ram_addra, ram_dia}, {data_addr, data_wdata});
        check("ram_enb", ram_enb, fg || drg);
        if (fg)  check("ram_addrb_f", ram_addrb, fetch_addr);
        if (drg) check("ram_addrb_d", ram_addrb, data_addr);
        check("pri_state", dbg_pri_state, m_pri);
        obs_fg  = fetch_gnt;
        obs_dg  = data_gnt;
        obs_drv = data_rvalid;
        m_fg    = fg;
        m_dg    = d_wr || drg;
        // A read sees the word as it stands after this cycle's write.
        if (d_wr) exp_mem[data_addr] = data_wdata;
        if (fg)  exp_fq.push_back(exp_mem[fetch_addr]);
        if (drg) exp_dq.push_back(exp_mem[data_addr]);
        if (!m_lock) begin
            if (fetch_req && d_rd) begin
                m_cnt++;
                if (m_cnt == MAX_BURST) begin
                    m_pri = !m_pri;
                    m_cnt = 0;
                end
            end else begin
                m_cnt = 0;
            end
        end
        if (d_wr) m_lock = 1'b0;
        else if (drg) m_lock = data_lock;
        @(posedge clka);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 9) == 0) ? AW'(10'h3FF) : AW'($urandom_range(0, 7));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        model_reset();
        @(posedge clka);
        #1;
        // 1: held in reset with a fetch pending, then released
        fetch_req  = 1'b1;
        fetch_addr = 10'h000;
        reset_cycle();
        reset_cycle();
        rst = 1'b1;
        step();
        check("t1_gnt", obs_fg, 1);
        fetch_req = 1'b0;
        #3;
        check("t1_rdata", {fetch_rvalid, fetch_rdata}, {1'b1, 16'h0401});
        #0;
        @(posedge clka);
        #1;
        exp_fq.delete();

        // 2: both read continuously
        fetch_req  = 1'b1;
        fetch_addr = 10'h004;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 10'h005;
        for (int i = 0; i < 16; i++) begin
            step();
            check("t2_pattern", obs_fg, ((i / 4) % 2) == 0);
            check("t2_one_gnt", obs_fg && obs_dg, 0);
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        step();

        // 3: write and fetch of the same word in one cycle
        fetch_req  = 1'b1;
        fetch_addr = 10'h020;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 10'h020;
        data_wdata = 16'hBEEF;
        step();
        check("t3_gnts", {obs_fg, obs_dg}, 2'b11);
        data_req = 1'b0;
        data_we  = 1'b0;
        #3;
        check("t3_fwd", fetch_rdata, 16'hBEEF);
        #0;
        step();
        fetch_req = 1'b0;
        #3;
        check("t3_ram", fetch_rdata, 16'hBEEF);
        #0;
        step();

        // 4: locked read-modify-write holds off fetch
        fetch_req  = 1'b1;
        fetch_addr = 10'h031;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 10'h030;
        data_lock  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = m_dg;
        end
        check("t4_lock_gnt", ok, 1);
        data_req  = 1'b0;
        data_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_blocked", obs_fg, 0);
        end
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_wdata = 16'h5A5A;
        step();
        check("t4_wr_cycle", {obs_fg, obs_dg}, 2'b01);
        data_req = 1'b0;
        data_we  = 1'b0;
        step();
        check("t4_released", obs_fg, 1);
        fetch_req = 1'b0;
        step();

        // 5: reset right after a fetch grant, with priority moved to data beforehand
        fetch_req = 1'b1;
        data_req  = 1'b1;
        data_we   = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            step();
            ok = m_pri;
        end
        check("t5_pri_data", ok, 1);
        data_req = 1'b0;
        step();
        check("t5_gnt", obs_fg, 1);
        rst = 1'b0;
        reset_cycle();
        rst      = 1'b1;
        data_req = 1'b1;
        step();
        check("t5_fetch_wins", obs_fg, 1);

        // 6: data read withdrawn while fetch owns the port
        data_addr = 10'h055;
        step();
        check("t6_no_gnt", obs_dg, 0);
        data_req  = 1'b0;
        fetch_req = 1'b0;
        step();
        check("t6_no_gnt2", obs_dg, 0);
        step();
        check("t6_no_rvalid", obs_drv, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!fetch_req || m_fg) begin
                fetch_req  = ($urandom_range(0, 3) != 0);
                fetch_addr = rand_addr();
            end else if ($urandom_range(0, 7) == 0) begin
                fetch_req = 1'b0;
            end
            if (!data_req || m_dg) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_we    = ($urandom_range(0, 2) == 0);
                data_addr  = rand_addr();
                data_wdata = DW'($urandom);
                data_lock  = ($urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 3) == 0) begin
                data_req = 1'b0;
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                reset_cycle();
                rst = 1'b1;
                m_fg = 1'b0;
                m_dg = 1'b0;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
